// File: rtl/mandel_frame_scheduler_if.sv
// Engine-array and pixel-stream signals of mandel_frame_scheduler.
// master: the scheduler side. slave: the engine array and downstream pixel consumer.
interface mandel_frame_scheduler_if #(
  parameter int NUM_ENGINES      = 4,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int ITERATIONS_WIDTH = 6
);
  logic                                    frame_start;
  logic [NUM_ENGINES-1:0]                  eng_start;
  logic [PIXEL_DATA_WIDTH-1:0]             eng_x;
  logic [PIXEL_DATA_WIDTH-1:0]             eng_y;
  logic [NUM_ENGINES-1:0]                  eng_done;
  logic [NUM_ENGINES*ITERATIONS_WIDTH-1:0] eng_iter;
  logic [ITERATIONS_WIDTH-1:0]             iter_o;
  logic                                    valid;
  logic                                    ready;
  logic                                    first;
  logic                                    last_x;
  logic                                    last_y;
  logic                                    busy;

  modport master (
    input  frame_start, eng_done, eng_iter, ready,
    output eng_start, eng_x, eng_y, iter_o, valid, first, last_x, last_y, busy
  );

  modport slave (
    output frame_start, eng_done, eng_iter, ready,
    input  eng_start, eng_x, eng_y, iter_o, valid, first, last_x, last_y, busy
  );
endinterface

// File: rtl/mandel_frame_scheduler.sv
// Dynamic engine dispatch plus reorder buffer; emits iteration counts in raster order.
// Define MANDEL_SCHED_CONTINUOUS_EN to run frames back to back with no DRAIN phase.
module mandel_frame_scheduler #(
  parameter int NUM_ENGINES      = 4,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int ITERATIONS_WIDTH = 6,
  parameter int X_RES            = 640,
  parameter int Y_RES            = 480,
  parameter int ROB_DEPTH        = 16
) (
  input logic                      clk,
  input logic                      reset,
  mandel_frame_scheduler_if.master bus
);
  localparam int PW = PIXEL_DATA_WIDTH;
  localparam int IW = ITERATIONS_WIDTH;
  localparam int RW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int OW = $clog2(ROB_DEPTH + 1);
  localparam logic [PW-1:0] X_LAST  = PW'(X_RES - 1);
  localparam logic [PW-1:0] Y_LAST  = PW'(Y_RES - 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(ROB_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [PW-1:0]          rx_q, rx_d, ry_q, ry_d;
  logic [RW-1:0]          seq_q, seq_d, head_q, head_d;
  logic [OW-1:0]          outstanding_q, outstanding_d;
  logic [NUM_ENGINES-1:0] busy_mask_q, busy_mask_d;
  logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
  logic [PW-1:0]          eng_x_q, eng_x_d, eng_y_q, eng_y_d;
  logic                   busy_q, busy_d;
  logic [RW-1:0]          tag_q [NUM_ENGINES];
  logic [RW-1:0]          tag_d [NUM_ENGINES];
  logic [IW-1:0]          rob_iter_q [ROB_DEPTH];
  logic [IW-1:0]          rob_iter_d [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]   rob_vld_q, rob_vld_d;

  logic                   head_vld, retire, last_ret, found, dispatch, last_disp;
  logic [NUM_ENGINES-1:0] pick;

  always_comb begin
    head_vld  = rob_vld_q[head_q];
    retire    = head_vld && bus.ready;
    last_ret  = retire && (rx_q == X_LAST) && (ry_q == Y_LAST);

    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
      if (!found && !busy_mask_q[k]) begin
        pick[k] = 1'b1;
        found   = 1'b1;
      end
    end

    // frame_start in IDLE dispatches pixel (0,0) on the same edge that enters RUN,
    // so the first eng_start appears one cycle after frame_start is sampled.
    dispatch  = found && (outstanding_q < OUT_MAX) &&
                ((state_q == RUN) || ((state_q == IDLE) && bus.frame_start));
    last_disp = dispatch && (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);

    state_d       = state_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    rx_d          = rx_q;
    ry_d          = ry_q;
    seq_d         = seq_q;
    head_d        = head_q;
    busy_mask_d   = busy_mask_q;
    eng_start_d   = '0;
    eng_x_d       = eng_x_q;
    eng_y_d       = eng_y_q;
    tag_d         = tag_q;
    rob_iter_d    = rob_iter_q;
    rob_vld_d     = rob_vld_q;

    for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
      if (bus.eng_done[k] && busy_mask_q[k]) begin
        rob_iter_d[tag_q[k]] = bus.eng_iter[k*IW +: IW];
        rob_vld_d[tag_q[k]]  = 1'b1;
        busy_mask_d[k]       = 1'b0;
      end
    end

    if (retire) begin
      rob_vld_d[head_q] = 1'b0;
      head_d            = head_q + RW'(1);
      if (rx_q == X_LAST) begin
        rx_d = '0;
        ry_d = (ry_q == Y_LAST) ? '0 : ry_q + PW'(1);
      end else begin
        rx_d = rx_q + PW'(1);
      end
    end

    if (dispatch) begin
      eng_start_d = pick;
      eng_x_d     = x_cnt_q;
      eng_y_d     = y_cnt_q;
      busy_mask_d = busy_mask_d | pick;
      for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
        if (pick[k]) tag_d[k] = seq_q;
      end
      seq_d = seq_q + RW'(1);
      if (x_cnt_q == X_LAST) begin
        x_cnt_d = '0;
        y_cnt_d = (y_cnt_q == Y_LAST) ? '0 : y_cnt_q + PW'(1);
      end else begin
        x_cnt_d = x_cnt_q + PW'(1);
      end
    end

    outstanding_d = outstanding_q + OW'(dispatch) - OW'(retire);

    case (state_q)
      IDLE:    if (bus.frame_start) state_d = RUN;
      RUN: begin
`ifdef MANDEL_SCHED_CONTINUOUS_EN
        state_d = RUN;
`else
        state_d = last_disp ? DRAIN : RUN;
`endif
      end
      DRAIN:   if (last_ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      rx_q          <= '0;
      ry_q          <= '0;
      seq_q         <= '0;
      head_q        <= '0;
      outstanding_q <= '0;
      busy_mask_q   <= '0;
      eng_start_q   <= '0;
      eng_x_q       <= '0;
      eng_y_q       <= '0;
      busy_q        <= 1'b0;
      rob_vld_q     <= '0;
      for (int unsigned k = 0; k < NUM_ENGINES; k++) tag_q[k] <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) rob_iter_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      rx_q          <= rx_d;
      ry_q          <= ry_d;
      seq_q         <= seq_d;
      head_q        <= head_d;
      outstanding_q <= outstanding_d;
      busy_mask_q   <= busy_mask_d;
      eng_start_q   <= eng_start_d;
      eng_x_q       <= eng_x_d;
      eng_y_q       <= eng_y_d;
      busy_q        <= busy_d;
      rob_vld_q     <= rob_vld_d;
      tag_q         <= tag_d;
      rob_iter_q    <= rob_iter_d;
    end
  end

  // Flags are qualified by valid so the idle (0,0) retire position never reads as first.
  assign bus.eng_start = eng_start_q;
  assign bus.eng_x     = eng_x_q;
  assign bus.eng_y     = eng_y_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = head_vld;
  assign bus.iter_o    = head_vld ? rob_iter_q[head_q] : '0;
  assign bus.first     = head_vld && (rx_q == '0) && (ry_q == '0);
  assign bus.last_x    = head_vld && (rx_q == X_LAST);
  assign bus.last_y    = head_vld && (rx_q == X_LAST) && (ry_q == Y_LAST);
endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Scoreboard bench for mandel_frame_scheduler: modelled engines, raster-order expectations queue.
module tb_mandel_frame_scheduler;
  localparam int N  = 4;
  localparam int PW = 10;
  localparam int IW = 6;
  localparam int XR = 8;
  localparam int YR = 4;
  localparam int RD = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mandel_frame_scheduler_if #(.NUM_ENGINES(N), .PIXEL_DATA_WIDTH(PW), .ITERATIONS_WIDTH(IW)) bus ();

  mandel_frame_scheduler #(
    .NUM_ENGINES(N), .PIXEL_DATA_WIDTH(PW), .ITERATIONS_WIDTH(IW),
    .X_RES(XR), .Y_RES(YR), .ROB_DEPTH(RD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [IW-1:0] iter;
    logic          first;
    logic          last_x;
    logic          last_y;
  } beat_t;

  beat_t         exp_q[$];
  int            compared = 0;
  int            mismatched = 0;
  int            disp_cnt = 0, ret_cnt = 0, beats = 0, peak = 0;
  int            lat [N];
  int            cnt [N];
  logic [IW-1:0] res [N];
  bit            stale_req = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frames(input int frames);
    beat_t b;
    for (int f = 0; f < frames; f++)
      for (int y = 0; y < YR; y++)
        for (int x = 0; x < XR; x++) begin
          b.iter   = IW'(x + y);
          b.first  = (x == 0) && (y == 0);
          b.last_x = (x == XR - 1);
          b.last_y = (x == XR - 1) && (y == YR - 1);
          exp_q.push_back(b);
        end
  endtask

  task automatic start_frame(input int frames);
    bus.frame_start = 1'b1;
    push_frames(frames);
    tick();
    bus.frame_start = 1'b0;
    check("first_dispatch_start", int'(bus.eng_start), 1);
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic wait_beats(input int target, input bit drop, input string name);
    int n = 0;
    while (beats < target && n < 4000) begin
      tick();
      n++;
    end
    if (drop) bus.ready = 1'b0;
    if (beats < target) fail_now(name);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_eng_start"}, int'(bus.eng_start), 0);
    check({name, "_eng_x"}, int'(bus.eng_x), 0);
    check({name, "_eng_y"}, int'(bus.eng_y), 0);
    check({name, "_iter_o"}, int'(bus.iter_o), 0);
    check({name, "_valid"}, int'(bus.valid), 0);
    check({name, "_flags"}, int'({bus.first, bus.last_x, bus.last_y}), 0);
    check({name, "_busy"}, int'(bus.busy), 0);
  endtask

  // Engine array model: fixed per-engine latency, result = x + y.
  initial begin
    bit was_busy;
    bus.eng_done = '0;
    bus.eng_iter = '0;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    forever begin
      tick();
      bus.eng_done = '0;
      if (stale_req) begin
        bus.eng_done = '1;
        bus.eng_iter = '1;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        stale_req = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          was_busy = (cnt[k] != 0);
          if (cnt[k] > 0) begin
            cnt[k]--;
            if (cnt[k] == 0) begin
              bus.eng_done[k]            = 1'b1;
              bus.eng_iter[k*IW +: IW]   = res[k];
            end
          end
          if (bus.eng_start[k]) begin
            check("start_to_free_engine", int'(was_busy), 0);
            cnt[k] = lat[k];
            res[k] = IW'(bus.eng_x + bus.eng_y);
          end
        end
      end
    end
  end

  // Monitor: dispatch order, outstanding tracking, stall stability, scoreboard pops.
  initial begin
    beat_t e, snap;
    bit    stalled = 1'b0;
    int    ex = 0, ey = 0, outst;
    forever begin
      @(negedge clk);
      if (reset) begin
        disp_cnt = 0;
        ret_cnt  = 0;
        ex       = 0;
        ey       = 0;
        stalled  = 1'b0;
        continue;
      end
      if (bus.eng_start != '0) begin
        check("dispatch_onehot", $countones(bus.eng_start), 1);
        check("dispatch_x", int'(bus.eng_x), ex);
        check("dispatch_y", int'(bus.eng_y), ey);
        if (ex == XR - 1) begin
          ex = 0;
          ey = (ey == YR - 1) ? 0 : ey + 1;
        end else begin
          ex++;
        end
        disp_cnt++;
      end
      outst = disp_cnt - ret_cnt;
      if (outst > peak) peak = outst;
      if (stalled) begin
        check("stall_valid", int'(bus.valid), 1);
        check("stall_iter", int'(bus.iter_o), int'(snap.iter));
        check("stall_flags", int'({bus.first, bus.last_x, bus.last_y}),
              int'({snap.first, snap.last_x, snap.last_y}));
      end
      stalled     = bus.valid && !bus.ready;
      snap.iter   = bus.iter_o;
      snap.first  = bus.first;
      snap.last_x = bus.last_x;
      snap.last_y = bus.last_y;
      if (bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL extra_beat: got iter %0d expected no beat at %0t", bus.iter_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat_iter", int'(bus.iter_o), int'(e.iter));
          check("beat_first", int'(bus.first), int'(e.first));
          check("beat_last_x", int'(bus.last_x), int'(e.last_x));
          check("beat_last_y", int'(bus.last_y), int'(e.last_y));
        end
        ret_cnt++;
        beats++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got %0d beats", beats);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.ready       = 1'b0;
    for (int k = 0; k < N; k++) lat[k] = 3;

    repeat (2) tick();
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (5) begin
      tick();
      check("idle_no_dispatch", int'(bus.eng_start), 0);
    end
    check("idle_busy", int'(bus.busy), 0);

`ifdef MANDEL_SCHED_CONTINUOUS_EN
    bus.ready = 1'b1;
    start_frame(2);
    wait_beats(64, 1'b1, "cont_beats");
    check("cont_busy_stays", int'(bus.busy), 1);
    check("cont_queue_empty", exp_q.size(), 0);
`else
    // Nominal frame.
    bus.ready = 1'b1;
    start_frame(1);
    wait_drain("nominal_drain");
    repeat (2) tick();
    check("nominal_busy_idle", int'(bus.busy), 0);
    check("nominal_valid_idle", int'(bus.valid), 0);

    // Slow engine 0: nothing may leave before pixel 0 completes.
    lat[0] = 20;
    for (int k = 1; k < N; k++) lat[k] = 2;
    peak = 0;
    start_frame(1);
    check("ooo_no_valid", int'(bus.valid), 0);
    repeat (20) begin
      tick();
      check("ooo_no_valid", int'(bus.valid), 0);
    end
    wait_drain("ooo_drain");
    check("ooo_peak_outstanding", peak, RD);
    repeat (2) tick();
    check("ooo_busy_idle", int'(bus.busy), 0);
    for (int k = 0; k < N; k++) lat[k] = 3;

    // Backpressure mid-frame.
    start_frame(1);
    wait_beats(beats + 12, 1'b1, "bp_pre");
    repeat (50) tick();
    check("bp_outstanding", disp_cnt - ret_cnt, RD);
    bus.ready = 1'b1;
    wait_drain("bp_drain");
    repeat (2) tick();
    check("bp_busy_idle", int'(bus.busy), 0);

    // Reset mid-frame followed by stale completions.
    start_frame(1);
    wait_beats(beats + 10, 1'b1, "rst_pre");
    reset = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    check_outputs_zero("midreset");
    reset     = 1'b0;
    stale_req = 1'b1;
    repeat (6) begin
      tick();
      check("stale_no_valid", int'(bus.valid), 0);
      check("stale_no_start", int'(bus.eng_start), 0);
    end
    bus.ready = 1'b1;
    start_frame(1);
    wait_drain("post_reset_drain");
    repeat (2) tick();
    check("post_reset_busy_idle", int'(bus.busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
